frame_boundary_padder: RTL and testbench

- Parametrised successor to the in-line boundary insertion ahead of the filter stage.
- Buffers a demosaiced multi-channel pixel stream in an internal show-ahead FIFO.
- Emits a fully padded frame of (height+2B) rows × (width+2B) pixels, with B=(kernelSize-1)/2, in raster order for the kernelSize×kernelSize filter.
- Generalises frame size, kernel size, channel count and pixel width, and adds a constant-value pad mode, overflow detection and an explicit frame FSM.

---
 rtl/frame_boundary_padder_if.sv | 29 ++
 rtl/frame_boundary_padder.sv | 183 ++++++++++++++++++
 tb/tb_frame_boundary_padder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_boundary_padder_if.sv
// Pixel-stream bundle for frame_boundary_padder: frame control, input write port and padded output port.
// The master side drives frame control and input pixels; the slave side (the padder) drives the rest.
interface frame_boundary_padder_if #(
  parameter int dataWidth  = 24,
  parameter int levelWidth = 11
);
  logic                  newFrame;
  logic                  padMode;
  logic [dataWidth-1:0]  padValue;
  logic                  iValid;
  logic [dataWidth-1:0]  iData;
  logic                  iReady;
  logic                  oValid;
  logic [dataWidth-1:0]  oData;
  logic                  oFirst;
  logic                  oDone;
  logic                  oOverflow;
  logic [levelWidth-1:0] oFifoLevel;

  modport master (
    output newFrame, padMode, padValue, iValid, iData,
    input  iReady, oValid, oData, oFirst, oDone, oOverflow, oFifoLevel
  );

  modport slave (
    input  newFrame, padMode, padValue, iValid, iData,
    output iReady, oValid, oData, oFirst, oDone, oOverflow, oFifoLevel
  );
endinterface

// File: rtl/frame_boundary_padder.sv
// Pads a buffered pixel stream to (height+2B)x(width+2B) in raster order; first pixel 1 cycle after newFrame.
// Only DATA (and replicate-mode LEFT) stall on an empty FIFO; FRAME_BOUNDARY_PADDER_REPLICATE_EN adds edge replication.
module frame_boundary_padder #(
  parameter int width      = 320,
  parameter int height     = 240,
  parameter int kernelSize = 7,
  parameter int channels   = 3,
  parameter int pixelWidth = 8,
  parameter int fifoDepth  = 1024
) (
  input logic                   clk,
  input logic                   reset,
  frame_boundary_padder_if.slave bus
);
  localparam int dataW  = channels * pixelWidth;
  localparam int addrW  = $clog2(fifoDepth);
  localparam int levelW = addrW + 1;

  localparam logic [31:0] bord    = 32'((kernelSize - 1) / 2);
  localparam logic [31:0] rowLen  = 32'(width) + 2 * bord;
  localparam logic [31:0] bandLen = bord * rowLen;
  localparam logic [31:0] lastCol = 32'(width - 1);
  localparam logic [31:0] lastRow = 32'(height - 1);
  localparam logic [levelW-1:0] fullLevel = levelW'(fifoDepth);

  localparam logic [2:0] sIdle   = 3'd0;
  localparam logic [2:0] sTop    = 3'd1;
  localparam logic [2:0] sLeft   = 3'd2;
  localparam logic [2:0] sData   = 3'd3;
  localparam logic [2:0] sRight  = 3'd4;
  localparam logic [2:0] sBottom = 3'd5;
  localparam logic [2:0] sDone   = 3'd6;

  logic [dataW-1:0]  mem [fifoDepth];
  logic [addrW-1:0]  wrPtr, rdPtr;
  logic [levelW-1:0] level;
  logic              wrEn, rdEn, fifoEmpty;
  logic [dataW-1:0]  head;

  logic [2:0]        state;
  logic [31:0]       cnt, rowCnt;
  logic              padModeQ;
  logic [dataW-1:0]  padValueQ;
  logic [dataW-1:0]  constPix, bandPix, leftPix, rightPix;
  logic              leftStall;
  logic              oValidQ, oFirstQ, oDoneQ, overflowQ;
  logic [dataW-1:0]  oDataQ;

  // Ready reflects occupancy before this cycle's pop, so a full FIFO refuses a same-cycle write.
  assign bus.iReady     = (level != fullLevel);
  assign fifoEmpty      = (level == '0);
  assign head           = mem[rdPtr];
  assign wrEn           = bus.iValid && bus.iReady;
  assign rdEn           = (state == sData) && !fifoEmpty;
  assign bus.oFifoLevel = level;
  assign bus.oValid     = oValidQ;
  assign bus.oData      = oDataQ;
  assign bus.oFirst     = oFirstQ;
  assign bus.oDone      = oDoneQ;
  assign bus.oOverflow  = overflowQ;

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= bus.iData;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (rdEn) rdPtr <= rdPtr + 1'b1;
      case ({wrEn, rdEn})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  assign constPix = padModeQ ? padValueQ : '0;

`ifdef FRAME_BOUNDARY_PADDER_REPLICATE_EN
  logic             replicate;
  logic [dataW-1:0] lastPix;

  // All-ones constant selects replication; top/bottom bands stay zero in that mode.
  assign replicate = padModeQ && (&padValueQ);
  assign bandPix   = replicate ? '0 : constPix;
  assign leftPix   = replicate ? head : constPix;
  assign rightPix  = replicate ? lastPix : constPix;
  assign leftStall = replicate && fifoEmpty;

  always_ff @(posedge clk) begin
    if (!reset)     lastPix <= '0;
    else if (rdEn)  lastPix <= head;
  end
`else
  assign bandPix   = constPix;
  assign leftPix   = constPix;
  assign rightPix  = constPix;
  assign leftStall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= sIdle;
      cnt       <= '0;
      rowCnt    <= '0;
      padModeQ  <= 1'b0;
      padValueQ <= '0;
      oValidQ   <= 1'b0;
      oDataQ    <= '0;
      oFirstQ   <= 1'b0;
      oDoneQ    <= 1'b0;
      overflowQ <= 1'b0;
    end else begin
      oValidQ <= 1'b0;
      oFirstQ <= 1'b0;
      oDoneQ  <= 1'b0;
      if (bus.iValid && !bus.iReady) overflowQ <= 1'b1;
      case (state)
        sIdle: if (bus.newFrame) begin
          padModeQ  <= bus.padMode;
          padValueQ <= bus.padValue;
          cnt       <= '0;
          rowCnt    <= '0;
          state     <= sTop;
        end
        sTop: begin
          oValidQ <= 1'b1;
          oDataQ  <= bandPix;
          oFirstQ <= (cnt == '0);
          if (cnt == bandLen - 32'd1) begin
            cnt   <= '0;
            state <= sLeft;
          end else cnt <= cnt + 32'd1;
        end
        sLeft: if (!leftStall) begin
          oValidQ <= 1'b1;
          oDataQ  <= leftPix;
          if (cnt == bord - 32'd1) begin
            cnt   <= '0;
            state <= sData;
          end else cnt <= cnt + 32'd1;
        end
        sData: if (rdEn) begin
          oValidQ <= 1'b1;
          oDataQ  <= head;
          if (cnt == lastCol) begin
            cnt   <= '0;
            state <= sRight;
          end else cnt <= cnt + 32'd1;
        end
        sRight: begin
          oValidQ <= 1'b1;
          oDataQ  <= rightPix;
          if (cnt == bord - 32'd1) begin
            cnt <= '0;
            if (rowCnt < lastRow) begin
              rowCnt <= rowCnt + 32'd1;
              state  <= sLeft;
            end else state <= sBottom;
          end else cnt <= cnt + 32'd1;
        end
        sBottom: begin
          oValidQ <= 1'b1;
          oDataQ  <= bandPix;
          if (cnt == bandLen - 32'd1) begin
            cnt   <= '0;
            state <= sDone;
          end else cnt <= cnt + 32'd1;
        end
        sDone: begin
          oDoneQ <= 1'b1;
          state  <= sIdle;
        end
        default: state <= sIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_boundary_padder.sv
// Directed bench for frame_boundary_padder with a 4x3 frame, 3x3 kernel and a 16-deep FIFO.
module tb_frame_boundary_padder;
  localparam int frameLen = 30;

  logic clk = 1'b0;
  logic reset;
  int   nChecks = 0;
  int   nBad = 0;

  frame_boundary_padder_if #(.dataWidth(24), .levelWidth(5)) bus ();

  frame_boundary_padder #(
    .width(4), .height(3), .kernelSize(3), .channels(3), .pixelWidth(8), .fifoDepth(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [23:0] capQ[$];
  int          capCyc[$];
  int          cycle = 0;
  int          firstCnt = 0;
  int          firstIdx = -1;
  int          doneCnt = 0;
  int          doneCyc = 0;
  int          lastValidCyc = 0;

  always @(negedge clk) begin
    cycle++;
    if (bus.oValid) begin
      if (bus.oFirst) begin
        firstCnt++;
        firstIdx = capQ.size();
      end
      capQ.push_back(bus.oData);
      capCyc.push_back(cycle);
      lastValidCyc = cycle;
    end
    if (bus.oDone) begin
      doneCnt++;
      doneCyc = cycle;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] expPix(int idx, logic [23:0] pad, bit rep);
    int r = idx / 6;
    int c = idx % 6;
    if (r == 0 || r == 4) return rep ? 24'h0 : pad;
    if (c == 0) return rep ? 24'((r - 1) * 4 + 1) : pad;
    if (c == 5) return rep ? 24'((r - 1) * 4 + 4) : pad;
    return 24'((r - 1) * 4 + c);
  endfunction

  task automatic clearCapture();
    capQ.delete();
    capCyc.delete();
    firstCnt = 0;
    firstIdx = -1;
  endtask

  task automatic pushPix(input logic [23:0] v);
    bus.iValid = 1'b1;
    bus.iData  = v;
    @(posedge clk); #1;
    bus.iValid = 1'b0;
  endtask

  task automatic preload();
    for (int i = 1; i <= 12; i++) pushPix(24'(i));
  endtask

  task automatic startFrame(input string tag, input logic mode, input logic [23:0] val);
    bus.padMode  = mode;
    bus.padValue = val;
    bus.newFrame = 1'b1;
    @(posedge clk); #1;
    bus.newFrame = 1'b0;
    chk({tag, "_lat0"}, 32'(bus.oValid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_first"}, 32'({bus.oValid, bus.oFirst}), 32'd3);
  endtask

  task automatic waitDone(input string tag);
    int start = doneCnt;
    int n = 0;
    while (doneCnt == start && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_timeout"}, 32'(doneCnt != start), 32'd1);
  endtask

  task automatic checkFrame(input string tag, input logic [23:0] pad, input bit rep);
    chk({tag, "_count"}, 32'(capQ.size()), frameLen);
    chk({tag, "_firstIdx"}, 32'(firstIdx), 32'd0);
    chk({tag, "_firstCnt"}, 32'(firstCnt), 32'd1);
    chk({tag, "_doneLat"}, 32'(doneCyc - lastValidCyc), 32'd1);
    for (int i = 0; i < frameLen && i < capQ.size(); i++)
      chk($sformatf("%s_pix%0d", tag, i), 32'(capQ[i]), 32'(expPix(i, pad, rep)));
  endtask

  initial begin
    int savedSize;
    int savedDone;

    reset        = 1'b0;
    bus.newFrame = 1'b0;
    bus.padMode  = 1'b0;
    bus.padValue = '0;
    bus.iValid   = 1'b0;
    bus.iData    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_oValid",   32'(bus.oValid),     32'd0);
    chk("rst_oData",    32'(bus.oData),      32'd0);
    chk("rst_oFirst",   32'(bus.oFirst),     32'd0);
    chk("rst_oDone",    32'(bus.oDone),      32'd0);
    chk("rst_overflow", 32'(bus.oOverflow),  32'd0);
    chk("rst_iReady",   32'(bus.iReady),     32'd1);
    chk("rst_level",    32'(bus.oFifoLevel), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Zero pad, preloaded.
    preload();
    chk("zero_level", 32'(bus.oFifoLevel), 32'd12);
    clearCapture();
    startFrame("zero", 1'b0, 24'h0);
    waitDone("zero");
    checkFrame("zero", 24'h0, 1'b0);
    chk("zero_drained", 32'(bus.oFifoLevel), 32'd0);

    // Constant pad.
    preload();
    clearCapture();
    startFrame("const", 1'b1, 24'h0A0B0C);
    waitDone("const");
    checkFrame("const", 24'h0A0B0C, 1'b0);

    // Starved input: one pixel every three cycles.
    clearCapture();
    startFrame("starve", 1'b0, 24'h0);
    for (int i = 1; i <= 12; i++) begin
      pushPix(24'(i));
      repeat (2) begin @(posedge clk); #1; end
    end
    waitDone("starve");
    checkFrame("starve", 24'h0, 1'b0);
    if (capCyc.size() >= 7)
      chk("starve_topLeftRun", 32'(capCyc[6] - capCyc[0]), 32'd6);
    chk("starve_gaps", 32'(doneCyc - capCyc[0] > frameLen), 32'd1);

    // Overflow: 20 back-to-back writes into a 16-deep FIFO while idle.
    for (int i = 1; i <= 20; i++) begin
      pushPix(24'(i));
      if (i == 16) begin
        chk("ovf_readyFall", 32'(bus.iReady),    32'd0);
        chk("ovf_notYet",    32'(bus.oOverflow), 32'd0);
      end
    end
    chk("ovf_flag",  32'(bus.oOverflow),  32'd1);
    chk("ovf_level", 32'(bus.oFifoLevel), 32'd16);
    clearCapture();
    startFrame("ovf", 1'b0, 24'h0);
    waitDone("ovf");
    checkFrame("ovf", 24'h0, 1'b0);
    chk("ovf_remainder", 32'(bus.oFifoLevel), 32'd4);
    chk("ovf_sticky",    32'(bus.oOverflow),  32'd1);

    // Reset in the middle of the first data row.
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    preload();
    clearCapture();
    startFrame("mid", 1'b0, 24'h0);
    repeat (8) begin @(posedge clk); #1; end
    savedDone = doneCnt;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("mid_oValid",   32'(bus.oValid),     32'd0);
    chk("mid_level",    32'(bus.oFifoLevel), 32'd0);
    chk("mid_overflow", 32'(bus.oOverflow),  32'd0);
    chk("mid_iReady",   32'(bus.iReady),     32'd1);
    savedSize = capQ.size();
    repeat (20) begin @(posedge clk); #1; end
    chk("mid_silent", 32'(capQ.size() - savedSize), 32'd0);
    chk("mid_noDone", 32'(doneCnt - savedDone),     32'd0);
    preload();
    clearCapture();
    startFrame("clean", 1'b0, 24'h0);
    waitDone("clean");
    checkFrame("clean", 24'h0, 1'b0);

    // All-ones pad value: replication when built in, an ordinary constant otherwise.
    preload();
    clearCapture();
    startFrame("ones", 1'b1, 24'hFFFFFF);
    waitDone("ones");
`ifdef FRAME_BOUNDARY_PADDER_REPLICATE_EN
    checkFrame("ones", 24'hFFFFFF, 1'b1);
`else
    checkFrame("ones", 24'hFFFFFF, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end
endmodule
